// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the MMIO port bank: channel stride, default bases, index widths.
package mmio_pkg;

  localparam int unsigned CH_STRIDE    = 4;
  localparam logic [31:0] IN_BASE_DEF  = 32'h0000_0000;
  localparam logic [31:0] OUT_BASE_DEF = 32'h0000_0040;

  // Index width that stays legal (>=1 bit) for single-entry ranges.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mmio_arbiter.sv
// Drain arbiter: lowest-index pending channel wins; a starvation counter forces a one-cycle CPU stall.
module mmio_arbiter
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned STARVE_MAX = 64,
  localparam int unsigned IW        = idx_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] pend_i,
  input  logic              cpu_cs_i,
  output logic              drain_c_o,
  output logic [IW-1:0]     drain_idx_c_o,
  output logic              stall_c_o
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_any_c;

  assign pend_any_c = |pend_i;

  // Scan downwards so the lowest pending index is the last one written.
  always_comb begin
    drain_idx_c_o = '0;
    for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
      if (pend_i[i]) drain_idx_c_o = IW'(i);
    end
  end

  assign stall_c_o = pend_any_c & (cnt_q == CW'(STARVE_MAX));
  assign drain_c_o = pend_any_c & (~cpu_cs_i | stall_c_o);

  always_comb begin
    cnt_d = '0;
    if (pend_any_c && !drain_c_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped I/O bank: queued touch injections merged into idle DataMem cycles, output channels,
// registered display readback. Optional output-write interrupt when MMIO_OUT_IRQ_EN is defined.
module mmio_port_bank
  import mmio_pkg::*;
#(
  parameter int unsigned       NUM_IN     = 4,
  parameter int unsigned       NUM_OUT    = 4,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] IN_BASE    = ADDR_W'(IN_BASE_DEF),
  parameter logic [ADDR_W-1:0] OUT_BASE   = ADDR_W'(OUT_BASE_DEF),
  parameter int unsigned       STARVE_MAX = 64,
  localparam int unsigned      IW         = idx_w(NUM_IN),
  localparam int unsigned      DW         = idx_w(NUM_IN + NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inj_valid,
  input  logic [IW-1:0]             inj_sel,
  input  logic [DATA_W-1:0]         inj_data,
  output logic                      inj_ready,
  input  logic                      cpu_cs,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic                      cpu_stall,
  output logic                      mem_cs,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [NUM_OUT*DATA_W-1:0] out_val,
  output logic [NUM_OUT-1:0]        out_upd,
  input  logic [DW-1:0]             disp_sel,
  output logic [DATA_W-1:0]         disp_data
`ifdef MMIO_OUT_IRQ_EN
  ,
  output logic                      irq,
  input  logic                      irq_ack
`endif
);

  localparam int unsigned       OW       = idx_w(NUM_OUT);
  localparam logic [ADDR_W-1:0] IN_SPAN  = ADDR_W'(CH_STRIDE * NUM_IN);
  localparam logic [ADDR_W-1:0] OUT_SPAN = ADDR_W'(CH_STRIDE * NUM_OUT);

  logic [NUM_IN-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0]  pdata_q   [NUM_IN];
  logic [DATA_W-1:0]  pdata_d   [NUM_IN];
  logic [DATA_W-1:0]  in_val_q  [NUM_IN];
  logic [DATA_W-1:0]  in_val_d  [NUM_IN];
  logic [DATA_W-1:0]  out_val_q [NUM_OUT];
  logic [DATA_W-1:0]  out_val_d [NUM_OUT];
  logic [NUM_OUT-1:0] out_upd_q, out_upd_d;
  logic [DATA_W-1:0]  disp_q, disp_d;

  logic              drain_c, stall_c;
  logic [IW-1:0]     drain_idx_c;
  logic              cpu_go_c, cpu_wr_c, in_hit_c, out_hit_c;
  logic [ADDR_W-1:0] in_off_c, out_off_c;
  logic [IW-1:0]     in_idx_c;
  logic [OW-1:0]     out_idx_c;
  logic [31:0]       disp_idx_c;

  mmio_arbiter #(
    .NUM_IN     (NUM_IN),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk           (clk),
    .rst           (rst),
    .pend_i        (pend_q),
    .cpu_cs_i      (cpu_cs),
    .drain_c_o     (drain_c),
    .drain_idx_c_o (drain_idx_c),
    .stall_c_o     (stall_c)
  );

  // Address decode; offsets wrap below the base, so a single compare bounds each range.
  assign cpu_go_c   = cpu_cs & ~stall_c;
  assign cpu_wr_c   = cpu_go_c & cpu_we;
  assign in_off_c   = cpu_addr - IN_BASE;
  assign out_off_c  = cpu_addr - OUT_BASE;
  assign in_hit_c   = in_off_c < IN_SPAN;
  assign out_hit_c  = out_off_c < OUT_SPAN;
  assign in_idx_c   = IW'(in_off_c >> 2);
  assign out_idx_c  = OW'(out_off_c >> 2);
  assign disp_idx_c = 32'(disp_sel);

  assign inj_ready = ~pend_q[inj_sel] | (drain_c & (drain_idx_c == inj_sel));
  assign cpu_stall = stall_c;

  // DataMem port: CPU has priority unless stalled; otherwise drain an injection.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_go_c) begin
      mem_cs    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (drain_c) begin
      mem_cs    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = IN_BASE + (ADDR_W'(drain_idx_c) << 2);
      mem_wdata = pdata_q[drain_idx_c];
    end
  end

  // Injection applied after drain so a draining slot can be refilled in the same cycle.
  always_comb begin
    pend_d    = pend_q;
    pdata_d   = pdata_q;
    in_val_d  = in_val_q;
    out_val_d = out_val_q;
    out_upd_d = '0;
    disp_d    = '0;
    if (drain_c) pend_d[drain_idx_c] = 1'b0;
    if (cpu_wr_c && in_hit_c) in_val_d[in_idx_c] = cpu_wdata;
    if (cpu_wr_c && out_hit_c) begin
      out_val_d[out_idx_c] = cpu_wdata;
      out_upd_d[out_idx_c] = 1'b1;
    end
    if (inj_valid && inj_ready) begin
      pend_d[inj_sel]   = 1'b1;
      pdata_d[inj_sel]  = inj_data;
      in_val_d[inj_sel] = inj_data;
    end
    if (disp_idx_c < NUM_IN)
      disp_d = in_val_q[IW'(disp_idx_c)];
    else if (disp_idx_c < NUM_IN + NUM_OUT)
      disp_d = out_val_q[OW'(disp_idx_c - NUM_IN)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      out_upd_q <= '0;
      disp_q    <= '0;
      for (int i = 0; i < int'(NUM_IN); i++) begin
        pdata_q[i]  <= '0;
        in_val_q[i] <= '0;
      end
      for (int i = 0; i < int'(NUM_OUT); i++) out_val_q[i] <= '0;
    end else begin
      pend_q    <= pend_d;
      pdata_q   <= pdata_d;
      in_val_q  <= in_val_d;
      out_val_q <= out_val_d;
      out_upd_q <= out_upd_d;
      disp_q    <= disp_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_OUT); g++) begin : g_out
    assign out_val[g*DATA_W +: DATA_W] = out_val_q[g];
  end
  assign out_upd   = out_upd_q;
  assign disp_data = disp_q;

`ifdef MMIO_OUT_IRQ_EN
  // A new update wins over a simultaneous acknowledge.
  logic irq_q, irq_d;
  always_comb irq_d = (|out_upd_q) | (irq_q & ~irq_ack);
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end
  assign irq = irq_q;
`endif

endmodule
